pwm_core: RTL

//  PWM generator fed by the four AXI4-Lite slave registers of the myAXIpwm IP (0x0 CTRL, 0x4 PERIOD, 0x8 DUTY, 0xC PRESCALE).

---
 rtl/pwm_pkg.sv | 39 +++
 rtl/pwm_prescaler.sv | 29 ++
 rtl/pwm_core.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the PWM core.
//  - CTRL register bit positions and AXI register offsets of the myAXIpwm IP
//  - FSM state encoding
//  - decoded CTRL struct plus a helper that decodes the raw register bits
package pwm_pkg;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_POL     = 1;
  localparam int CTRL_ONESHOT = 2;
  localparam int CTRL_IRQEN   = 3;

  localparam logic [3:0] REG_CTRL     = 4'h0;
  localparam logic [3:0] REG_PERIOD   = 4'h4;
  localparam logic [3:0] REG_DUTY     = 4'h8;
  localparam logic [3:0] REG_PRESCALE = 4'hC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pwm_state_t;

  typedef struct packed {
    logic irq_en;
    logic oneshot;
    logic pol;
    logic en;
  } pwm_ctrl_t;

  function automatic pwm_ctrl_t decode_ctrl(input logic [3:0] c);
    pwm_ctrl_t d;
    d.en      = c[CTRL_EN];
    d.pol     = c[CTRL_POL];
    d.oneshot = c[CTRL_ONESHOT];
    d.irq_en  = c[CTRL_IRQEN];
    return d;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: tick generator for the PWM counter.
//  gclk       in   clock
//  grst_n     in   async active-low reset
//  run        in   count enable; when low the divider is held at 0
//  prescale   in   divide value, used live (not shadowed)
//  tick       out  high for one cycle every (prescale+1) cycles while running
module pwm_prescaler #(
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   gclk,
  input  logic                   grst_n,
  input  logic                   run,
  input  logic [PRESC_WIDTH-1:0] prescale,
  output logic                   tick
);

  logic [PRESC_WIDTH-1:0] presc_cnt;

  // >= rather than == so that lowering prescale below the current count
  // wraps back to 0 on the next cycle instead of running to the top.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)                          presc_cnt <= '0;
    else if (!run || presc_cnt >= prescale) presc_cnt <= '0;
    else                                  presc_cnt <= presc_cnt + 1'b1;
  end

  assign tick = run && (presc_cnt == prescale);

endmodule

// File: rtl/pwm_core.sv
// pwm_core: PWM generator driven by the myAXIpwm register values.
//  ACLK         in   clock, rising edge
//  ARESETN      in   async active-low reset
//  ctrl         in   [0] EN, [1] POL, [2] ONESHOT, [3] IRQ_EN; upper bits ignored
//  period       in   waveform period is (period+1) ticks
//  duty         in   active ticks per period
//  prescale     in   one tick every (prescale+1) cycles
//  irq_clr      in   pulse, clears irq
//  pwm_out      out  registered waveform
//  period_done  out  one-cycle pulse at each period end
//  irq          out  sticky interrupt
//  busy         out  high while running
//  cnt_value    out  period counter readback
// Period and duty are shadowed and only reloaded at a period boundary, so
// register writes never produce runt pulses.
module pwm_core
  import pwm_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int CNT_WIDTH          = 16,
  parameter int PRESC_WIDTH        = 8
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] ctrl,
  input  logic [CNT_WIDTH-1:0]          period,
  input  logic [CNT_WIDTH-1:0]          duty,
  input  logic [PRESC_WIDTH-1:0]        prescale,
  input  logic                          irq_clr,
  output logic                          pwm_out,
  output logic                          period_done,
  output logic                          irq,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          cnt_value
);

  pwm_ctrl_t             cfg;
  pwm_state_t            state;
  logic                  en_q;
  logic                  tick;
  logic                  presc_run;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  period_sh;
  logic [CNT_WIDTH-1:0]  duty_sh;
  logic                  ctrl_unused;

  assign cfg         = decode_ctrl(ctrl[3:0]);
  assign ctrl_unused = ^ctrl[C_S_AXI_DATA_WIDTH-1:4];

  // Divider only runs in RUN with EN still high; dropping EN clears it in
  // the same edge that returns the FSM to IDLE.
  assign presc_run = (state == RUN) && cfg.en;

  pwm_prescaler #(
    .PRESC_WIDTH (PRESC_WIDTH)
  ) u_presc (
    .gclk     (ACLK),
    .grst_n   (ARESETN),
    .run      (presc_run),
    .prescale (prescale),
    .tick     (tick)
  );

  // en_q resets high: an EN already asserted when reset releases must not
  // look like a rising edge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= IDLE;
      en_q        <= 1'b1;
      cnt         <= '0;
      period_sh   <= '0;
      duty_sh     <= '0;
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
      irq         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      en_q        <= cfg.en;
      period_done <= 1'b0;
      pwm_out     <= cfg.pol;

      // set (from the visible period_done pulse) beats clear
      if (period_done && cfg.irq_en) irq <= 1'b1;
      else if (irq_clr)              irq <= 1'b0;

      case (state)
        IDLE: begin
          if (cfg.en && !en_q) begin
            state     <= RUN;
            busy      <= 1'b1;
            cnt       <= '0;
            period_sh <= period;
            duty_sh   <= duty;
          end
        end
        RUN: begin
          // duty_sh > period_sh makes this always true: 100% duty
          pwm_out <= (cnt < duty_sh) ^ cfg.pol;
          if (!cfg.en) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (tick) begin
            if (cnt == period_sh) begin
              cnt         <= '0;
              period_done <= 1'b1;
              period_sh   <= period;
              duty_sh     <= duty;
              if (cfg.oneshot) begin
                state <= HALT;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HALT: begin
          if (!cfg.en) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign cnt_value = cnt;

endmodule
